// File: rtl/eeprom_arbiter.sv
// eeprom_arbiter
//
// Purpose: two-client round-robin arbiter and sequencer for the serial EEPROM
// read/write engine. It picks one requesting client, registers that client's
// address, write byte and direction toward the engine, and holds the engine's
// WR/RD command until the engine returns ACK. For a read it captures the
// engine's byte, then pulses DONE to the winning client.
//
// Ports:
//   clk_i               system clock, rising edge
//   reset_ni            synchronous active-low reset
//   req0_i / req1_i     client requests, held high until the matching done
//   we0_i / we1_i       1 = write, 0 = read
//   addr0_i / addr1_i   client byte addresses
//   wdata0_i / wdata1_i client write bytes
//   gnt0_o / gnt1_o     client owns the engine (issue through done)
//   done0_o / done1_o   one-cycle completion pulses
//   err0_o / err1_o     one-cycle timeout pulses (watchdog builds only)
//   rdata_o             read byte, valid in the done cycle of a read
//   e_wr_o / e_rd_o     engine command levels
//   e_addr_o, e_wdata_o registered address and write byte to the engine
//   e_rdata_i, e_ack_i  engine read byte and one-cycle completion pulse
//
// Configuration: define EEPROM_ARB_TIMEOUT_EN to build in an ACK watchdog of
// TIMEOUT cycles. Without it, WAIT lasts until E_ACK and err0_o/err1_o are 0.

module eeprom_arbiter #(
  parameter int          ADDR_W  = 11,
  parameter int          DATA_W  = 8,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              e_wr_o,
  output logic              e_rd_o,
  output logic [ADDR_W-1:0] e_addr_o,
  output logic [DATA_W-1:0] e_wdata_o,
  input  logic [DATA_W-1:0] e_rdata_i,
  input  logic              e_ack_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              e_wr_q, e_wr_d, e_rd_q, e_rd_d;
  logic [ADDR_W-1:0] e_addr_q, e_addr_d;
  logic [DATA_W-1:0] e_wdata_q, e_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              winner;

`ifdef EEPROM_ARB_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        err0_q, err0_d, err1_q, err1_d;
`endif

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    e_wr_d    = e_wr_q;
    e_rd_d    = e_rd_q;
    e_addr_d  = e_addr_q;
    e_wdata_d = e_wdata_q;
    rdata_d   = rdata_q;
    winner    = 1'b0;
`ifdef EEPROM_ARB_TIMEOUT_EN
    wdog_d    = wdog_q;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          // Lone requester wins; on a tie the client not served last wins.
          winner    = (req0_i && req1_i) ? ~last_q : req1_i;
          owner_d   = winner;
          wr_d      = winner ? we1_i : we0_i;
          e_addr_d  = winner ? addr1_i : addr0_i;
          e_wdata_d = winner ? wdata1_i : wdata0_i;
          gnt0_d    = ~winner;
          gnt1_d    = winner;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        e_wr_d  = wr_q;
        e_rd_d  = ~wr_q;
        state_d = StWait;
`ifdef EEPROM_ARB_TIMEOUT_EN
        wdog_d  = 16'd0;
`endif
      end
      StWait: begin
        // ACK takes priority over a watchdog expiry in the same cycle.
        if (e_ack_i) begin
          e_wr_d  = 1'b0;
          e_rd_d  = 1'b0;
          if (!wr_q) begin
            rdata_d = e_rdata_i;
          end
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = StDone;
        end
`ifdef EEPROM_ARB_TIMEOUT_EN
        else if (wdog_q == (TIMEOUT - 16'd1)) begin
          e_wr_d  = 1'b0;
          e_rd_d  = 1'b0;
          done0_d = ~owner_q;
          done1_d = owner_q;
          err0_d  = ~owner_q;
          err1_d  = owner_q;
          state_d = StDone;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        last_d  = owner_q;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset also drops any engine command at once.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      e_wr_q    <= 1'b0;
      e_rd_q    <= 1'b0;
      e_addr_q  <= '0;
      e_wdata_q <= '0;
      rdata_q   <= '0;
`ifdef EEPROM_ARB_TIMEOUT_EN
      wdog_q    <= 16'd0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      e_wr_q    <= e_wr_d;
      e_rd_q    <= e_rd_d;
      e_addr_q  <= e_addr_d;
      e_wdata_q <= e_wdata_d;
      rdata_q   <= rdata_d;
`ifdef EEPROM_ARB_TIMEOUT_EN
      wdog_q    <= wdog_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
`endif
    end
  end

`ifdef EEPROM_ARB_TIMEOUT_EN
  assign err0_o = err0_q;
  assign err1_o = err1_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign err0_o = 1'b0;
  assign err1_o = 1'b0;
`endif

  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign done0_o   = done0_q;
  assign done1_o   = done1_q;
  assign rdata_o   = rdata_q;
  assign e_wr_o    = e_wr_q;
  assign e_rd_o    = e_rd_q;
  assign e_addr_o  = e_addr_q;
  assign e_wdata_o = e_wdata_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// tb_eeprom_arbiter
//
// Purpose: self-checking bench for eeprom_arbiter. A small behavioural model
// (last-served client, last read byte) predicts the winner, the engine-side
// values and the completion outputs of every transaction. The bench plays the
// engine itself, acknowledging after a chosen delay. Inputs are driven and
// outputs sampled on the falling clock edge.
//
// The watchdog scenario is only built when EEPROM_ARB_TIMEOUT_EN is defined.

module tb_eeprom_arbiter;

  logic        clk;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [10:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [7:0]  rdata;
  logic        e_wr, e_rd;
  logic [10:0] e_addr;
  logic [7:0]  e_wdata;
  logic [7:0]  e_rdata;
  logic        e_ack;

  int          tests_run;
  int          tests_failed;

  // Reference model state: last-served client and the byte RDATA should hold.
  int          mLast;
  logic [7:0]  mRdata;

  // Observations gathered while playing the engine for one transaction.
  typedef struct {
    int          lat;
    logic [1:0]  gnt;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [1:0]  cmd;
    int          hi;
    logic [5:0]  fin;
    logic [7:0]  rdata;
    logic [1:0]  gntHold;
    logic [3:0]  rel;
  } obs_t;

  // Expected values of one transaction, derived from the arbitration rules.
  typedef struct {
    int          w;
    logic [1:0]  gnt;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [1:0]  cmd;
    logic [5:0]  fin;
    logic [7:0]  rdata;
  } exp_t;

  eeprom_arbiter #(
    .ADDR_W (11),
    .DATA_W (8),
    .TIMEOUT(16'd16)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .req0_i   (req0),
    .req1_i   (req1),
    .we0_i    (we0),
    .we1_i    (we1),
    .addr0_i  (addr0),
    .addr1_i  (addr1),
    .wdata0_i (wdata0),
    .wdata1_i (wdata1),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .done0_o  (done0),
    .done1_o  (done1),
    .err0_o   (err0),
    .err1_o   (err1),
    .rdata_o  (rdata),
    .e_wr_o   (e_wr),
    .e_rd_o   (e_rd),
    .e_addr_o (e_addr),
    .e_wdata_o(e_wdata),
    .e_rdata_i(e_rdata),
    .e_ack_i  (e_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model prediction for the next transaction from the current client inputs.
  function automatic exp_t predict(input logic [7:0] rd);
    exp_t e;
    logic isWrite;
    if (req0 && req1) e.w = (mLast == 0) ? 1 : 0;
    else              e.w = req1 ? 1 : 0;
    isWrite = (e.w == 1) ? we1 : we0;
    e.gnt   = (e.w == 1) ? 2'b10 : 2'b01;
    e.addr  = (e.w == 1) ? addr1 : addr0;
    e.wdata = (e.w == 1) ? wdata1 : wdata0;
    e.cmd   = isWrite ? 2'b10 : 2'b01;
    e.fin   = (e.w == 1) ? 6'b100000 : 6'b010000;
    e.rdata = isWrite ? mRdata : rd;
    return e;
  endfunction

  // Plays the engine for one transaction and records what the DUT showed.
  // Called on a falling edge; returns on the falling edge after GNT drops.
  task automatic run_txn(input int delay, input logic [7:0] rd, output obs_t o);
    logic [1:0] firstCmd;
    o.lat = 0;
    while (!(gnt0 || gnt1) && o.lat < 30) begin
      @(negedge clk);
      o.lat++;
    end
    o.gnt   = {gnt1, gnt0};
    o.addr  = e_addr;
    o.wdata = e_wdata;
    @(negedge clk);
    firstCmd = {e_wr, e_rd};
    o.cmd    = firstCmd;
    o.hi     = 1;
    e_rdata  = rd;
    repeat (delay) begin
      @(negedge clk);
      if ({e_wr, e_rd} === firstCmd) o.hi++;
    end
    e_ack = 1'b1;
    @(negedge clk);
    e_ack     = 1'b0;
    e_rdata   = 8'($urandom);
    o.fin     = {done1, done0, err1, err0, e_wr, e_rd};
    o.rdata   = rdata;
    o.gntHold = {gnt1, gnt0};
    @(negedge clk);
    o.rel = {gnt1, gnt0, done1, done0};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({gnt0, gnt1, done0, done1, err0, err1, e_wr, e_rd, e_addr, e_wdata, rdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got gnt=%b%b done=%b%b cmd=%b%b addr=%h wdata=%h rdata=%h, want all 0",
               gnt1, gnt0, done1, done0, e_wr, e_rd, e_addr, e_wdata, rdata);
    end
    reset_n = 1'b1;
    mLast   = 1;
    mRdata  = 8'h00;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({gnt0, gnt1, e_wr, e_rd} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: got gnt=%b%b cmd=%b%b want 0", gnt1, gnt0, e_wr, e_rd);
    end
  endtask

  task automatic test_single_write();
    obs_t o;
    exp_t e;
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h155; wdata0 = 8'hA5;
    e = predict(8'h00);
    run_txn(10, 8'h5A, o);
    req0 = 1'b0;
    tests_run++;
    if (o.lat !== 1 || o.gnt !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL write_grant: got lat=%0d gnt=%b want lat=1 gnt=01", o.lat, o.gnt);
    end
    tests_run++;
    if ({o.addr, o.wdata, o.cmd} !== {11'h155, 8'hA5, 2'b10}) begin
      tests_failed++;
      $display("[TB] FAIL write_engine: got addr=%h wdata=%h cmd=%b want 155 a5 10", o.addr, o.wdata, o.cmd);
    end
    tests_run++;
    if (o.hi !== 11) begin
      tests_failed++;
      $display("[TB] FAIL write_cmd_len: got %0d cycles want 11", o.hi);
    end
    tests_run++;
    if ({o.fin, o.rdata, o.gntHold, o.rel} !== {e.fin, e.rdata, 2'b01, 4'b0000}) begin
      tests_failed++;
      $display("[TB] FAIL write_done: got fin=%b rdata=%h hold=%b rel=%b want fin=%b rdata=%h hold=01 rel=0000",
               o.fin, o.rdata, o.gntHold, o.rel, e.fin, e.rdata);
    end
    mLast  = e.w;
    mRdata = e.rdata;
  endtask

  task automatic test_single_read();
    obs_t o;
    exp_t e;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h7FF; wdata1 = 8'h00;
    e = predict(8'h3C);
    run_txn(4, 8'h3C, o);
    req1 = 1'b0;
    tests_run++;
    if ({o.gnt, o.addr, o.cmd} !== {2'b10, 11'h7FF, 2'b01}) begin
      tests_failed++;
      $display("[TB] FAIL read_issue: got gnt=%b addr=%h cmd=%b want 10 7ff 01", o.gnt, o.addr, o.cmd);
    end
    tests_run++;
    if ({o.fin, o.rdata} !== {6'b100000, 8'h3C} || o.rdata !== e.rdata) begin
      tests_failed++;
      $display("[TB] FAIL read_done: got fin=%b rdata=%h want 100000 3c", o.fin, o.rdata);
    end
    mLast  = e.w;
    mRdata = e.rdata;
  endtask

  task automatic test_contention();
    obs_t o;
    exp_t e;
    logic [7:0] rd;
    req0 = 1'b1; we0 = 1'($urandom); addr0 = 11'($urandom); wdata0 = 8'($urandom);
    req1 = 1'b1; we1 = 1'($urandom); addr1 = 11'($urandom); wdata1 = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      e  = predict(rd);
      run_txn(int'($urandom_range(0, 5)), rd, o);
      tests_run++;
      if (o.gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10) || o.gnt !== e.gnt) begin
        tests_failed++;
        $display("[TB] FAIL contention_order[%0d]: got gnt=%b want %b", i, o.gnt, e.gnt);
      end
      tests_run++;
      if ({o.addr, o.wdata, o.cmd, o.fin, o.rdata, o.rel} !== {e.addr, e.wdata, e.cmd, e.fin, e.rdata, 4'b0000}) begin
        tests_failed++;
        $display("[TB] FAIL contention_txn[%0d]: got addr=%h wdata=%h cmd=%b fin=%b rdata=%h rel=%b want %h %h %b %b %h 0000",
                 i, o.addr, o.wdata, o.cmd, o.fin, o.rdata, o.rel, e.addr, e.wdata, e.cmd, e.fin, e.rdata);
      end
      if (i > 0) begin
        tests_run++;
        if (o.lat !== 1) begin
          tests_failed++;
          $display("[TB] FAIL back_to_back_lat[%0d]: got %0d want 1", i, o.lat);
        end
      end
      mLast  = e.w;
      mRdata = e.rdata;
      if (e.w == 0) begin
        we0 = 1'($urandom); addr0 = 11'($urandom); wdata0 = 8'($urandom);
      end else begin
        we1 = 1'($urandom); addr1 = 11'($urandom); wdata1 = 8'($urandom);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spurious_ack();
    obs_t o;
    exp_t e;
    logic [5:0] seen;
    seen  = '0;
    e_ack = 1'b1;
    @(negedge clk);
    e_ack = 1'b0;
    repeat (3) begin
      seen = seen | {gnt1, gnt0, done1, done0, e_wr, e_rd};
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 6'b000000) begin
      tests_failed++;
      $display("[TB] FAIL spurious_ack: got activity=%b want 000000", seen);
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'($urandom); wdata1 = 8'($urandom);
    e = predict(8'hC3);
    run_txn(2, 8'hC3, o);
    req1 = 1'b0;
    tests_run++;
    if ({o.lat, o.gnt, o.cmd, o.fin, o.rdata} !== {32'd1, e.gnt, e.cmd, e.fin, e.rdata}) begin
      tests_failed++;
      $display("[TB] FAIL after_spurious: got lat=%0d gnt=%b cmd=%b fin=%b rdata=%h want 1 %b %b %b %h",
               o.lat, o.gnt, o.cmd, o.fin, o.rdata, e.gnt, e.cmd, e.fin, e.rdata);
    end
    mLast  = e.w;
    mRdata = e.rdata;
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    exp_t e;
    int   n;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h2AA; wdata0 = 8'h11;
    n = 0;
    while (!gnt0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tests_run++;
    if ({e_wr, e_rd} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL midwait_cmd: got cmd=%b want 01", {e_wr, e_rd});
    end
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({gnt0, gnt1, done0, done1, err0, err1, e_wr, e_rd, e_addr, e_wdata, rdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midwait_reset: got gnt=%b%b done=%b%b cmd=%b%b addr=%h rdata=%h want all 0",
               gnt1, gnt0, done1, done0, e_wr, e_rd, e_addr, rdata);
    end
    reset_n = 1'b1;
    mLast   = 1;
    mRdata  = 8'h00;
    e = predict(8'h77);
    run_txn(3, 8'h77, o);
    req0 = 1'b0;
    tests_run++;
    if ({o.lat, o.gnt, o.addr, o.cmd, o.fin, o.rdata} !== {32'd1, e.gnt, e.addr, e.cmd, e.fin, e.rdata}) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_txn: got lat=%0d gnt=%b addr=%h cmd=%b fin=%b rdata=%h want 1 %b %h %b %b %h",
               o.lat, o.gnt, o.addr, o.cmd, o.fin, o.rdata, e.gnt, e.addr, e.cmd, e.fin, e.rdata);
    end
    mLast  = e.w;
    mRdata = e.rdata;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [7:0] rd;
    for (int i = 0; i < 16; i++) begin
      if (!req0) begin
        req0 = 1'($urandom); we0 = 1'($urandom); addr0 = 11'($urandom); wdata0 = 8'($urandom);
      end
      if (!req1) begin
        req1 = 1'($urandom); we1 = 1'($urandom); addr1 = 11'($urandom); wdata1 = 8'($urandom);
      end
      if (!req0 && !req1) req0 = 1'b1;
      rd = 8'($urandom);
      e  = predict(rd);
      run_txn(int'($urandom_range(0, 6)), rd, o);
      tests_run++;
      if ({o.gnt, o.addr, o.wdata, o.cmd, o.fin, o.rdata, o.gntHold, o.rel} !==
          {e.gnt, e.addr, e.wdata, e.cmd, e.fin, e.rdata, e.gnt, 4'b0000}) begin
        tests_failed++;
        $display("[TB] FAIL random_txn[%0d]: got gnt=%b addr=%h wdata=%h cmd=%b fin=%b rdata=%h rel=%b want %b %h %h %b %b %h 0000",
                 i, o.gnt, o.addr, o.wdata, o.cmd, o.fin, o.rdata, o.rel, e.gnt, e.addr, e.wdata, e.cmd, e.fin, e.rdata);
      end
      mLast  = e.w;
      mRdata = e.rdata;
      if (e.w == 0) req0 = 1'($urandom);
      else          req1 = 1'($urandom);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef EEPROM_ARB_TIMEOUT_EN
  task automatic test_watchdog();
    int n;
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h0F0; wdata0 = 8'h99;
    n = 0;
    while (!gnt0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n = 0;
    while (!done0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    req0 = 1'b0;
    tests_run++;
    if (n !== 16) begin
      tests_failed++;
      $display("[TB] FAIL watchdog_latency: got %0d cycles want 16", n);
    end
    tests_run++;
    if ({done0, err0, done1, err1, e_wr, e_rd, rdata} !== {6'b110000, mRdata}) begin
      tests_failed++;
      $display("[TB] FAIL watchdog_done: got done=%b err=%b cmd=%b%b rdata=%h want 1 1 00 %h",
               done0, err0, e_wr, e_rd, rdata, mRdata);
    end
    mLast = 0;
    @(negedge clk);
    tests_run++;
    if ({done0, err0, gnt0} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL watchdog_release: got done=%b err=%b gnt=%b want 000", done0, err0, gnt0);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mLast        = 1;
    mRdata       = 8'h00;
    reset_n      = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    e_rdata = '0;
    e_ack   = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_spurious_ack();
    test_reset_mid_wait();
    test_random();
`ifdef EEPROM_ARB_TIMEOUT_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL sim_timeout: bench did not complete within time limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
